// File: rtl/cpu_pkg.sv
// Shared CPU constants and types for the register file and its pending-write scoreboard.
package cpu_pkg;

  localparam int DATA_W    = 64;
  localparam int REG_IDX_W = 5;
  localparam int NREGS     = 32;
  localparam int CNT_W     = 2;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0]    word_t;
  typedef logic [CNT_W-1:0]     cnt_t;

  localparam reg_idx_t ZERO_REG = 5'd31;
  localparam cnt_t     CNT_MAX  = '1;

endpackage

// File: rtl/pend_counter.sv
// Per-register count of in-flight writes: saturating up/down counter with
// synchronous clear and a one-cycle underflow pulse when a retire finds it empty.
module pend_counter
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_next,
  output logic             underflow
);

  logic [CNT_W-1:0] cnt_reg;

  // Clear dominates; a simultaneous inc and dec cancel, even at zero.
  always_comb begin
    cnt_next  = cnt_reg;
    underflow = 1'b0;
    if (clr) begin
      cnt_next = '0;
    end else if (inc && !dec) begin
      if (cnt_reg != CNT_MAX) cnt_next = cnt_reg + 1'b1;
    end else if (dec && !inc) begin
      if (cnt_reg != '0) cnt_next = cnt_reg - 1'b1;
      else               underflow = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_reg <= '0;
    else        cnt_reg <= cnt_next;
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/regfile_scoreboard.sv
// Architectural register file with per-register pending-write scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-back forwarding to the read ports.
module regfile_scoreboard
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        rd_reg1,
  input  logic [4:0]        rd_reg2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_ready1,
  output logic              rd_ready2,
  output logic              stall,
  input  logic              issue_valid,
  input  logic [4:0]        issue_reg,
  output logic              issue_full,
  input  logic              wb_en,
  input  logic [4:0]        wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic [6:0]        inflight,
  output logic              wb_underflow
);

  word_t            regs_reg [NREGS];
  cnt_t             cnt_arr [NREGS];
  cnt_t             cnt_next_arr [NREGS];
  logic [NREGS-1:0] uflow_vec;
  logic [6:0]       inflight_reg;
  logic [6:0]       inflight_next;
  logic             wb_underflow_reg;
  logic             issue_acc;
  logic             retire;

  assign issue_full = issue_valid && (issue_reg != ZERO_REG) && (cnt_arr[issue_reg] == CNT_MAX);
  assign issue_acc  = issue_valid && !issue_full && (issue_reg != ZERO_REG) && !flush;
  assign retire     = wb_en && (wb_reg != ZERO_REG);

  // XZR has no counter; its slot is tied off so lookups need no guard.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_cnt
      if (gi == ZERO_REG) begin : g_zero
        assign cnt_arr[gi]      = '0;
        assign cnt_next_arr[gi] = '0;
        assign uflow_vec[gi]    = 1'b0;
      end else begin : g_pend
        pend_counter u_pend (
          .clk       (clk),
          .rst_n     (rst_n),
          .inc       (issue_acc && (issue_reg == reg_idx_t'(gi))),
          .dec       (retire && (wb_reg == reg_idx_t'(gi))),
          .clr       (flush),
          .cnt       (cnt_arr[gi]),
          .cnt_next  (cnt_next_arr[gi]),
          .underflow (uflow_vec[gi])
        );
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_reg[i] <= '0;
    end else if (retire) begin
      regs_reg[wb_reg] <= wb_data;
    end
  end

  // Summing next-state values keeps inflight aligned with the counters.
  always_comb begin
    inflight_next = '0;
    for (int i = 0; i < NREGS; i++) inflight_next = inflight_next + {5'b0, cnt_next_arr[i]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_reg     <= '0;
      wb_underflow_reg <= 1'b0;
    end else begin
      inflight_reg     <= inflight_next;
      wb_underflow_reg <= wb_underflow_reg | (|uflow_vec);
    end
  end

  assign inflight     = inflight_reg;
  assign wb_underflow = wb_underflow_reg;

  reg_idx_t rsel [2];
  word_t    rdata [2];
  logic     rready [2];

  assign rsel[0] = rd_reg1;
  assign rsel[1] = rd_reg2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      logic hit;
      assign hit = retire && (wb_reg == rsel[gi]);
`ifdef REGFILE_BYPASS_EN
      // A matching retire completes this cycle unless the same register is re-issued.
      assign rdata[gi]  = (rsel[gi] == ZERO_REG) ? '0 : (hit ? wb_data : regs_reg[rsel[gi]]);
      assign rready[gi] = (cnt_arr[rsel[gi]] == '0) ||
                          ((cnt_arr[rsel[gi]] == cnt_t'(1)) && hit &&
                           !(issue_acc && (issue_reg == rsel[gi])));
`else
      assign rdata[gi]  = (rsel[gi] == ZERO_REG) ? '0 : regs_reg[rsel[gi]];
      assign rready[gi] = (cnt_arr[rsel[gi]] == '0) || (hit && 1'b0);
`endif
    end
  endgenerate

  assign rd_data1  = rdata[0];
  assign rd_data2  = rdata[1];
  assign rd_ready1 = rready[0];
  assign rd_ready2 = rready[1];
  assign stall     = !(rready[0] && rready[1]) || issue_full;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard; expected write-back data is queued
// when driven and popped when read back.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rd_reg1, rd_reg2;
  logic [63:0] rd_data1, rd_data2;
  logic        rd_ready1, rd_ready2, stall;
  logic        issue_valid;
  logic [4:0]  issue_reg;
  logic        issue_full;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [63:0] wb_data;
  logic        flush;
  logic [6:0]  inflight;
  logic        wb_underflow;

  typedef struct {
    logic [4:0]  idx;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  regfile_scoreboard dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_reg1      (rd_reg1),
    .rd_reg2      (rd_reg2),
    .rd_data1     (rd_data1),
    .rd_data2     (rd_data2),
    .rd_ready1    (rd_ready1),
    .rd_ready2    (rd_ready2),
    .stall        (stall),
    .issue_valid  (issue_valid),
    .issue_reg    (issue_reg),
    .issue_full   (issue_full),
    .wb_en        (wb_en),
    .wb_reg       (wb_reg),
    .wb_data      (wb_data),
    .flush        (flush),
    .inflight     (inflight),
    .wb_underflow (wb_underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rd_reg1 = 5'd0; rd_reg2 = 5'd31;
    issue_valid = 1'b0; issue_reg = 5'd0; wb_en = 1'b0; wb_reg = 5'd0;
    wb_data = '0; flush = 1'b0;
    #12;
    n_cmp++; if (rd_data1 !== 64'd0) begin n_err++; $display("FAIL reset_rd_data1: got %h want 0", rd_data1); end
    n_cmp++; if (rd_data2 !== 64'd0) begin n_err++; $display("FAIL reset_rd_data2: got %h want 0", rd_data2); end
    n_cmp++; if (rd_ready1 !== 1'b1 || rd_ready2 !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b%b want 11", rd_ready1, rd_ready2); end
    n_cmp++; if (stall !== 1'b0 || issue_full !== 1'b0) begin n_err++; $display("FAIL reset_stall: got stall=%b full=%b want 0 0", stall, issue_full); end
    n_cmp++; if (inflight !== 7'd0 || wb_underflow !== 1'b0) begin n_err++; $display("FAIL reset_counts: got inflight=%0d uf=%b want 0 0", inflight, wb_underflow); end
    @(negedge clk); rst_n = 1'b1;
    tick();
    $display("reset: done");
  endtask

  task automatic test_issue_wb();
    exp_t e;
    issue_valid = 1'b1; issue_reg = 5'd5; tick();
    issue_valid = 1'b0; rd_reg1 = 5'd5; rd_reg2 = 5'd0; #1;
    n_cmp++; if (rd_ready1 !== 1'b0 || stall !== 1'b1) begin n_err++; $display("FAIL issue_x5_pending: got ready=%b stall=%b want 0 1", rd_ready1, stall); end
    n_cmp++; if (inflight !== 7'd1) begin n_err++; $display("FAIL issue_x5_inflight: got %0d want 1", inflight); end
    wb_en = 1'b1; wb_reg = 5'd5; wb_data = 64'h0000_0000_DEAD_BEEF;
    exp_q.push_back('{5'd5, 64'h0000_0000_DEAD_BEEF});
    tick();
    wb_en = 1'b0;
    e = exp_q.pop_front(); rd_reg1 = e.idx; #1;
    n_cmp++; if (rd_data1 !== e.data) begin n_err++; $display("FAIL wb_x5_data: got %h want %h", rd_data1, e.data); end
    n_cmp++; if (rd_ready1 !== 1'b1 || stall !== 1'b0 || inflight !== 7'd0) begin n_err++; $display("FAIL wb_x5_state: got ready=%b stall=%b inflight=%0d want 1 0 0", rd_ready1, stall, inflight); end
    $display("issue_wb: x5 read %h ready=%b", rd_data1, rd_ready1);
  endtask

  task automatic test_saturate();
    rd_reg1 = 5'd0; rd_reg2 = 5'd0;
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'b1; issue_reg = 5'd7; tick();
    end
    #1;
    n_cmp++; if (issue_full !== 1'b1 || stall !== 1'b1 || inflight !== 7'd3) begin n_err++; $display("FAIL sat_full: got full=%b stall=%b inflight=%0d want 1 1 3", issue_full, stall, inflight); end
    tick();
    n_cmp++; if (inflight !== 7'd3) begin n_err++; $display("FAIL sat_hold: got %0d want 3", inflight); end
    // Full counter: issue is held off, the retire alone drains one entry.
    wb_en = 1'b1; wb_reg = 5'd7; wb_data = 64'h77; #1;
    n_cmp++; if (issue_full !== 1'b1) begin n_err++; $display("FAIL sat_full_retire: got %b want 1", issue_full); end
    tick();
    n_cmp++; if (inflight !== 7'd2) begin n_err++; $display("FAIL sat_retire_blocked_issue: got %0d want 2", inflight); end
    n_cmp++; if (issue_full !== 1'b0) begin n_err++; $display("FAIL sat_not_full: got %b want 0", issue_full); end
    tick();
    n_cmp++; if (inflight !== 7'd2) begin n_err++; $display("FAIL sat_net_zero: got %0d want 2", inflight); end
    issue_valid = 1'b0; tick(); tick();
    wb_en = 1'b0; #1;
    n_cmp++; if (inflight !== 7'd0 || wb_underflow !== 1'b0) begin n_err++; $display("FAIL sat_drain: got inflight=%0d uf=%b want 0 0", inflight, wb_underflow); end
    $display("saturate: inflight=%0d", inflight);
  endtask

  task automatic test_flush();
    exp_t e;
    issue_valid = 1'b1; issue_reg = 5'd3; tick();
    issue_reg = 5'd4; tick();
    issue_valid = 1'b0; rd_reg1 = 5'd3; #1;
    n_cmp++; if (inflight !== 7'd2 || rd_ready1 !== 1'b0) begin n_err++; $display("FAIL flush_pre: got inflight=%0d ready=%b want 2 0", inflight, rd_ready1); end
    flush = 1'b1; issue_valid = 1'b1; issue_reg = 5'd6;
    wb_en = 1'b1; wb_reg = 5'd10; wb_data = 64'h1010_2020_3030_4040;
    exp_q.push_back('{5'd10, 64'h1010_2020_3030_4040});
    tick();
    flush = 1'b0; issue_valid = 1'b0; wb_en = 1'b0;
    rd_reg1 = 5'd6; #1;
    n_cmp++; if (inflight !== 7'd0 || rd_ready1 !== 1'b1) begin n_err++; $display("FAIL flush_x6: got inflight=%0d ready=%b want 0 1", inflight, rd_ready1); end
    rd_reg1 = 5'd3; rd_reg2 = 5'd4; #1;
    n_cmp++; if (rd_ready1 !== 1'b1 || rd_ready2 !== 1'b1 || stall !== 1'b0) begin n_err++; $display("FAIL flush_ready: got %b%b stall=%b want 11 0", rd_ready1, rd_ready2, stall); end
    n_cmp++; if (wb_underflow !== 1'b0) begin n_err++; $display("FAIL flush_no_uf: got %b want 0", wb_underflow); end
    e = exp_q.pop_front(); rd_reg2 = e.idx; #1;
    n_cmp++; if (rd_data2 !== e.data) begin n_err++; $display("FAIL flush_wb_data: got %h want %h", rd_data2, e.data); end
    $display("flush: inflight=%0d x10=%h", inflight, rd_data2);
  endtask

  task automatic test_bypass();
    issue_valid = 1'b1; issue_reg = 5'd2; tick();
    issue_valid = 1'b0; wb_en = 1'b1; wb_reg = 5'd2; wb_data = 64'hAA; tick();
    wb_en = 1'b0; issue_valid = 1'b1; issue_reg = 5'd2; tick();
    issue_valid = 1'b0;
    wb_en = 1'b1; wb_reg = 5'd2; wb_data = 64'h55;
    exp_q.push_back('{5'd2, 64'h55});
    rd_reg1 = 5'd2; rd_reg2 = 5'd0; #1;
`ifdef REGFILE_BYPASS_EN
    n_cmp++; if (rd_data1 !== 64'h55 || rd_ready1 !== 1'b1) begin n_err++; $display("FAIL bypass_same_cycle: got %h ready=%b want 55 1", rd_data1, rd_ready1); end
`else
    n_cmp++; if (rd_data1 !== 64'hAA || rd_ready1 !== 1'b0) begin n_err++; $display("FAIL nobypass_same_cycle: got %h ready=%b want aa 0", rd_data1, rd_ready1); end
`endif
    tick();
    wb_en = 1'b0; #1;
    n_cmp++; if (rd_data1 !== exp_q[0].data || rd_ready1 !== 1'b1) begin n_err++; $display("FAIL bypass_after: got %h ready=%b want %h 1", rd_data1, rd_ready1, exp_q[0].data); end
    void'(exp_q.pop_front());
    $display("bypass: x2=%h ready=%b", rd_data1, rd_ready1);
  endtask

  task automatic test_zero_reg();
    exp_t e;
    wb_en = 1'b1; wb_reg = 5'd31; wb_data = 64'h1234; tick();
    wb_en = 1'b0; rd_reg1 = 5'd31; rd_reg2 = 5'd31; #1;
    n_cmp++; if (rd_data1 !== 64'd0 || rd_ready1 !== 1'b1 || wb_underflow !== 1'b0) begin n_err++; $display("FAIL xzr_write: got %h ready=%b uf=%b want 0 1 0", rd_data1, rd_ready1, wb_underflow); end
    issue_valid = 1'b1; issue_reg = 5'd31; #1;
    n_cmp++; if (issue_full !== 1'b0 || stall !== 1'b0) begin n_err++; $display("FAIL xzr_issue: got full=%b stall=%b want 0 0", issue_full, stall); end
    tick();
    issue_valid = 1'b0;
    n_cmp++; if (inflight !== 7'd0) begin n_err++; $display("FAIL xzr_inflight: got %0d want 0", inflight); end
    wb_en = 1'b1; wb_reg = 5'd9; wb_data = 64'hCAFE_F00D_0000_0009;
    exp_q.push_back('{5'd9, 64'hCAFE_F00D_0000_0009});
    tick();
    wb_en = 1'b0;
    e = exp_q.pop_front(); rd_reg1 = e.idx; #1;
    n_cmp++; if (rd_data1 !== e.data) begin n_err++; $display("FAIL uf_x9_data: got %h want %h", rd_data1, e.data); end
    n_cmp++; if (wb_underflow !== 1'b1) begin n_err++; $display("FAIL uf_set: got %b want 1", wb_underflow); end
    tick(); tick();
    n_cmp++; if (wb_underflow !== 1'b1) begin n_err++; $display("FAIL uf_sticky: got %b want 1", wb_underflow); end
    $display("zero_reg: x9=%h uf=%b", rd_data1, wb_underflow);
  endtask

  task automatic test_reset_mid();
    issue_valid = 1'b1; issue_reg = 5'd12; tick();
    issue_valid = 1'b0; #1;
    n_cmp++; if (inflight !== 7'd1) begin n_err++; $display("FAIL mid_pre: got %0d want 1", inflight); end
    rst_n = 1'b0; rd_reg1 = 5'd12; rd_reg2 = 5'd5; #1;
    n_cmp++; if (inflight !== 7'd0 || rd_ready1 !== 1'b1 || wb_underflow !== 1'b0) begin n_err++; $display("FAIL mid_reset: got inflight=%0d ready=%b uf=%b want 0 1 0", inflight, rd_ready1, wb_underflow); end
    n_cmp++; if (rd_data2 !== 64'd0) begin n_err++; $display("FAIL mid_reset_data: got %h want 0", rd_data2); end
    @(negedge clk); rst_n = 1'b1;
    tick();
    wb_en = 1'b1; wb_reg = 5'd12; wb_data = 64'h12; tick();
    wb_en = 1'b0; #1;
    n_cmp++; if (wb_underflow !== 1'b1) begin n_err++; $display("FAIL mid_late_wb: got %b want 1", wb_underflow); end
    $display("reset_mid: uf=%b", wb_underflow);
  endtask

  initial begin
    test_reset();
    test_issue_wb();
    test_saturate();
    test_flush();
    test_bypass();
    test_zero_reg();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
